// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: parallel load, LSB-first serial sum through one
// full-adder cell, parallel registered result with a one-cycle done pulse.
module bit_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_nx;
    logic             last;
    logic             capture;

    assign s_bit   = a_sr[0] ^ b_sr[0] ^ c;
    assign c_nx    = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign last    = (cnt == CW'(WIDTH - 1));
    assign capture = load && (state == IDLE || state == LOADED);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (load) state_nx = LOADED;
            LOADED:  if (!load && start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res       <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (capture) begin
            // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
            a_sr <= A;
            b_sr <= B ^ {WIDTH{sub}};
            c    <= sub;
        end else if (state == LOADED && start) begin
            cnt <= '0;
        end else if (state == RUN) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            res  <= {s_bit, res[WIDTH-1:1]};
            c    <= c_nx;
            cnt  <= cnt + 1'b1;
            if (last) begin
                sum       <= {s_bit, res[WIDTH-1:1]};
                carry_out <= c_nx;
                overflow  <= c ^ c_nx;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub: WIDTH=8 and WIDTH=4 instances
// against a plain-arithmetic reference model.
module tb_bit_serial_addsub;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       rst_n8, load8, start8, sub8;
    logic [7:0] a8, b8, sum8;
    logic       co8, ov8, busy8, done8;

    logic       rst_n4, load4, start4, sub4;
    logic [3:0] a4, b4, sum4;
    logic       co4, ov4, busy4, done4;

    logic [31:0] last_sum8;

    always #5 clk = ~clk;

    bit_serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .load(load8), .start(start8), .sub(sub8),
        .A(a8), .B(b8), .sum(sum8), .carry_out(co8), .overflow(ov8),
        .busy(busy8), .done(done8)
    );

    bit_serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .load(load4), .start(start4), .sub(sub4),
        .A(a4), .B(b4), .sum(sum4), .carry_out(co4), .overflow(ov4),
        .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic modulo 2^w; overflow from true signed result.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic s, output logic [31:0] r, output logic co,
                         output logic ov);
        longint m, t, sa, sb, ideal;
        m  = (longint'(1) << w) - 1;
        t  = s ? (longint'(a) + ((~longint'(b)) & m) + 1) : (longint'(a) + longint'(b));
        r  = 32'(t & m);
        co = ((t >> w) & 1) != 0;
        sa = a[w-1] ? longint'(a) - (m + 1) : longint'(a);
        sb = b[w-1] ? longint'(b) - (m + 1) : longint'(b);
        ideal = s ? sa - sb : sa + sb;
        ov = (ideal > (m >> 1)) || (ideal < -((m >> 1) + 1));
    endtask

    task automatic load8_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        load8 = 1'b1; a8 = a; b8 = b; sub8 = s;
        @(posedge clk); @(negedge clk);
        load8 = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input bit toggle, input string tag);
        logic [31:0] r; logic co, ov;
        model(8, 32'(a), 32'(b), s, r, co, ov);
        start8 = 1'b1;
        @(posedge clk); @(negedge clk);
        start8 = 1'b0;
        chk({tag, " busy@E0"}, 32'(busy8), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            if (toggle) begin
                load8 = 1'($urandom); start8 = 1'($urandom);
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            end
            @(posedge clk); @(negedge clk);
            if (k < 8) begin
                chk({tag, " busy"}, 32'(busy8), 32'd1);
                chk({tag, " nodone"}, 32'(done8), 32'd0);
                chk({tag, " sum hold"}, 32'(sum8), last_sum8);
            end else begin
                load8 = 1'b0; start8 = 1'b0;
                chk({tag, " done"}, 32'(done8), 32'd1);
                chk({tag, " busy off"}, 32'(busy8), 32'd0);
                chk({tag, " sum"}, 32'(sum8), r);
                chk({tag, " carry"}, 32'(co8), 32'(co));
                chk({tag, " ovf"}, 32'(ov8), 32'(ov));
            end
        end
        last_sum8 = r;
        @(posedge clk); @(negedge clk);
        chk({tag, " done pulse"}, 32'(done8), 32'd0);
        chk({tag, " sum kept"}, 32'(sum8), r);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input string tag);
        logic [31:0] r; logic co, ov;
        model(4, 32'(a), 32'(b), s, r, co, ov);
        load4 = 1'b1; a4 = a; b4 = b; sub4 = s;
        @(posedge clk); @(negedge clk);
        load4 = 1'b0; start4 = 1'b1;
        @(posedge clk); @(negedge clk);
        start4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (k < 4) chk({tag, " busy"}, 32'(busy4), 32'd1);
        end
        chk({tag, " done"}, 32'(done4), 32'd1);
        chk({tag, " sum"}, 32'(sum4), r);
        chk({tag, " carry"}, 32'(co4), 32'(co));
        chk({tag, " ovf"}, 32'(ov4), 32'(ov));
        @(posedge clk); @(negedge clk);
        chk({tag, " done pulse"}, 32'(done4), 32'd0);
    endtask

    initial begin
        rst_n8 = 1'b0; load8 = 1'b0; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        rst_n4 = 1'b0; load4 = 1'b0; start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        last_sum8 = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst sum", 32'(sum8), 32'd0);
        chk("rst carry", 32'(co8), 32'd0);
        chk("rst ovf", 32'(ov8), 32'd0);
        chk("rst busy", 32'(busy8), 32'd0);
        chk("rst done", 32'(done8), 32'd0);
        rst_n8 = 1'b1; rst_n4 = 1'b1;
        @(negedge clk);

        load8_op(8'd100, 8'd27, 1'b0);  run8(8'd100, 8'd27, 1'b0, 0, "add100_27");
        load8_op(8'd200, 8'd100, 1'b0); run8(8'd200, 8'd100, 1'b0, 0, "add200_100");
        load8_op(8'd127, 8'd1, 1'b0);   run8(8'd127, 8'd1, 1'b0, 0, "add127_1");
        load8_op(8'd5, 8'd7, 1'b1);     run8(8'd5, 8'd7, 1'b1, 0, "sub5_7");
        load8_op(8'h80, 8'd1, 1'b1);    run8(8'h80, 8'd1, 1'b1, 0, "sub80_1");

        start8 = 1'b1;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("idle start busy", 32'(busy8), 32'd0);
            chk("idle start done", 32'(done8), 32'd0);
        end
        start8 = 1'b0;

        load8_op(8'd1, 8'd2, 1'b0);
        load8 = 1'b1; start8 = 1'b1; a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0;
        @(posedge clk); @(negedge clk);
        load8 = 1'b0; start8 = 1'b0;
        chk("load beats start", 32'(busy8), 32'd0);
        run8(8'd10, 8'd20, 1'b0, 0, "reload");

        load8_op(8'd77, 8'd99, 1'b1);
        run8(8'd77, 8'd99, 1'b1, 1, "toggle");

        load8_op(8'd50, 8'd60, 1'b0);
        start8 = 1'b1;
        @(posedge clk); @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n8 = 1'b0;
        #1;
        chk("midrst sum", 32'(sum8), 32'd0);
        chk("midrst carry", 32'(co8), 32'd0);
        chk("midrst ovf", 32'(ov8), 32'd0);
        chk("midrst busy", 32'(busy8), 32'd0);
        chk("midrst done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n8 = 1'b1;
        last_sum8 = 32'd0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            chk("midrst no done", 32'(done8), 32'd0);
        end
        load8_op(8'd3, 8'd4, 1'b0); run8(8'd3, 8'd4, 1'b0, 0, "after rst");

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb; logic rs; bit tg;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); tg = 1'($urandom);
            load8_op(ra, rb, rs);
            run8(ra, rb, rs, tg, "rand8");
        end

        op4(4'd9, 4'd8, 1'b0, "w4 9+8");
        for (int i = 0; i < 10; i++)
            op4(4'($urandom), 4'($urandom), 1'($urandom), "w4 b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
